// File: rtl/array_port_sched_pkg.sv
// ---------------------------------------------------------------------------
// array_sched_pkg
//   Shared definitions for the array port scheduler slice:
//     - sched_state_e : top-level FSM states (INIT zero-fill, RUN service)
//     - clog2_min1()  : ceil(log2(n)) but never less than 1, so index
//                       vectors stay legal when n is 1 or 2
//     - DEF_*         : default geometry of the SRAM macro and requester count
//     - RESP_ID_W     : response-id width for the default requester count
// ---------------------------------------------------------------------------
package array_sched_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_RD = 2;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 1024;

    localparam int RESP_ID_W = clog2_min1(DEF_NUM_RD);

endpackage

// File: rtl/array_port_sched_if.sv
// ---------------------------------------------------------------------------
// array_port_sched_if
//   Client-side bundle of the array port scheduler.
//     io_rreq_*  : NUM_RD read requesters (valid/ready/address, packed)
//     io_rresp_* : single read-response channel (valid/ready/id/data)
//     io_wreq_*  : single write stream (valid/ready/address/data)
//     io_init_done : array zero-fill complete
//   Modports:
//     slave  : the scheduler side
//     master : the client / environment side
// ---------------------------------------------------------------------------
interface array_port_sched_if
    import array_sched_pkg::*;
#(
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int ID_W = clog2_min1(NUM_RD);

    logic [NUM_RD-1:0]        io_rreq_valid;
    logic [NUM_RD-1:0]        io_rreq_ready;
    logic [NUM_RD*ADDR_W-1:0] io_rreq_addr;
    logic                     io_rresp_valid;
    logic                     io_rresp_ready;
    logic [ID_W-1:0]          io_rresp_id;
    logic [DATA_W-1:0]        io_rresp_data;
    logic                     io_wreq_valid;
    logic                     io_wreq_ready;
    logic [ADDR_W-1:0]        io_wreq_addr;
    logic [DATA_W-1:0]        io_wreq_data;
    logic                     io_init_done;

    modport slave (
        input  io_rreq_valid, io_rreq_addr, io_rresp_ready,
        input  io_wreq_valid, io_wreq_addr, io_wreq_data,
        output io_rreq_ready, io_rresp_valid, io_rresp_id, io_rresp_data,
        output io_wreq_ready, io_init_done
    );

    modport master (
        output io_rreq_valid, io_rreq_addr, io_rresp_ready,
        output io_wreq_valid, io_wreq_addr, io_wreq_data,
        input  io_rreq_ready, io_rresp_valid, io_rresp_id, io_rresp_data,
        input  io_wreq_ready, io_init_done
    );

endinterface

// File: rtl/array_rr_arbiter.sv
// ---------------------------------------------------------------------------
// array_rr_arbiter
//   Round-robin arbiter over NUM_RD requesters. The winner is the first
//   requester found scanning upward from (last winner + 1) modulo NUM_RD.
//   Ports:
//     clock, reset : clock, asynchronous active-high reset
//     req_i        : request vector
//     en_i         : arbitration allowed this cycle; gates grant_o and the
//                    pointer update
//     grant_o      : one-hot grant (all zero when !en_i or no request)
//     gidx_o       : index of the winner (valid when any_o)
//     any_o        : at least one request present (independent of en_i)
// ---------------------------------------------------------------------------
module array_rr_arbiter
    import array_sched_pkg::*;
#(
    parameter int  NUM_RD = DEF_NUM_RD,
    localparam int ID_W   = clog2_min1(NUM_RD)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_RD-1:0] req_i,
    input  logic              en_i,
    output logic [NUM_RD-1:0] grant_o,
    output logic [ID_W-1:0]   gidx_o,
    output logic              any_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    // Rotating priority scan; the modulo is done explicitly so requester
    // counts that are not a power of two wrap correctly.
    always_comb begin
        int              idx_i;
        logic [ID_W-1:0] idx_l;
        any_o  = 1'b0;
        gidx_o = '0;
        idx_i  = 0;
        idx_l  = '0;
        for (int k = 1; k <= NUM_RD; k++) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= NUM_RD) begin
                idx_i = idx_i - NUM_RD;
            end
            idx_l = ID_W'(idx_i);
            if (!any_o && req_i[idx_l]) begin
                any_o  = 1'b1;
                gidx_o = idx_l;
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (en_i && any_o) begin
            grant_o[gidx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && any_o) begin
            ptr_d = gidx_o;
        end
    end

    // Starting at NUM_RD-1 makes requester 0 the first winner after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= ID_W'(NUM_RD - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/array_port_sched.sv
// ---------------------------------------------------------------------------
// array_port_sched
//   Scheduler in front of one 1R1W synchronous SRAM macro whose read address
//   is registered (data valid the cycle after R0_en). Shares the read port
//   between NUM_RD requesters round-robin, forwards one write stream, and
//   zero-fills the whole array after every reset.
//   A read response is held without a data register: the macro keeps its
//   registered read address while R0_en is low, so the output stays stable
//   as long as no write lands on that address.
//   Ports:
//     clock, reset     : single clock, asynchronous active-high reset
//     bus (slave)      : read requests, read response, write stream,
//                        init-done flag (see array_port_sched_if)
//     R0_en/R0_addr    : macro read port (out)
//     R0_data          : macro read data (in), passed straight to the response
//     W0_en/W0_addr/W0_data : macro write port (out)
// ---------------------------------------------------------------------------
module array_port_sched
    import array_sched_pkg::*;
#(
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clock,
    input  logic               reset,
    array_port_sched_if.slave  bus,
    output logic               R0_en,
    output logic [ADDR_W-1:0]  R0_addr,
    input  logic [DATA_W-1:0]  R0_data,
    output logic               W0_en,
    output logic [ADDR_W-1:0]  W0_addr,
    output logic [DATA_W-1:0]  W0_data
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam int              ID_W     = clog2_min1(NUM_RD);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    sched_state_e      state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;

    logic              run;
    logic              accept;
    logic              issue_ok;
    logic              rd_fire;
    logic              wr_hazard;
    logic [NUM_RD-1:0] grant;
    logic [ID_W-1:0]   gidx;
    logic              any_req;
    logic [ADDR_W-1:0] gnt_addr;

    assign run    = (state_q == RUN);
    assign accept = pending_q & bus.io_rresp_ready;
    // A new read may start in the same cycle the held response is consumed,
    // which keeps back-to-back reads at one per cycle.
    assign issue_ok = run & (!pending_q | accept);
    assign rd_fire  = issue_ok & any_req;
    // Only a write that would overwrite a response still being held is
    // blocked; once the response is accepted the write may proceed.
    assign wr_hazard = pending_q & !accept & (bus.io_wreq_addr == hold_addr_q);

    array_rr_arbiter #(
        .NUM_RD (NUM_RD)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_i   (bus.io_rreq_valid),
        .en_i    (issue_ok),
        .grant_o (grant),
        .gidx_o  (gidx),
        .any_o   (any_req)
    );

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (grant[i]) begin
                gnt_addr = bus.io_rreq_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // FSM state register plus control registers (async reset)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Response id and held address are only observed while pending_q is set,
    // so they need no reset.
    always_ff @(posedge clock) begin
        id_q        <= id_d;
        hold_addr_q <= hold_addr_d;
    end

    // FSM next state and register next values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        id_d        = id_q;
        hold_addr_d = hold_addr_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        if (rd_fire) begin
            pending_d   = 1'b1;
            id_d        = gidx;
            hold_addr_d = gnt_addr;
        end else if (accept) begin
            pending_d = 1'b0;
        end
    end

    // FSM outputs
    always_comb begin
        bus.io_rreq_ready  = grant;
        bus.io_rresp_valid = pending_q;
        bus.io_rresp_id    = id_q;
        bus.io_rresp_data  = R0_data;
        bus.io_wreq_ready  = run & !wr_hazard;
        bus.io_init_done   = run;
        R0_en              = rd_fire;
        R0_addr            = gnt_addr;
        if (state_q == INIT) begin
            // Sweep writes zeros; the port stays quiet while reset is held.
            W0_en   = !reset;
            W0_addr = cnt_q[ADDR_W-1:0];
            W0_data = '0;
        end else begin
            W0_en   = bus.io_wreq_valid & bus.io_wreq_ready;
            W0_addr = bus.io_wreq_addr;
            W0_data = bus.io_wreq_data;
        end
    end

endmodule
